// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Picks which view code the display mux shows. Views are stepped manually
// with two pushbuttons or scanned automatically with a fixed dwell per view.
// A level request temporarily switches the display to the register-file view.
// Two code ranges exist: a normal range and a debug range.
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous, active-high
//   mode_auto        1 = auto-scan, 0 = manual stepping
//   debug_mode       0 = normal range, 1 = debug range
//   step_button      active-low pushbutton (asynchronous), advance one view
//   back_button      active-low pushbutton (asynchronous), go back one view
//   manual_load      load strobe for manual_select (manual state only)
//   manual_select    view code to load
//   rf_view_request  level request for the register-file view
//   display_select   registered view code
//   display_enable   registered, 1 while the register-file view is shown
//   auto_active      registered, 1 while auto-scanning

module display_scan_controller #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int NORMAL_LAST  = 26,
    parameter int DEBUG_BASE   = 32,
    parameter int DEBUG_LAST   = 38
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_auto,
    input  logic       debug_mode,
    input  logic       step_button,
    input  logic       back_button,
    input  logic       manual_load,
    input  logic [5:0] manual_select,
    input  logic       rf_view_request,
    output logic [5:0] display_select,
    output logic       display_enable,
    output logic       auto_active
);

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    localparam logic [5:0] NORM_BASE_C = 6'd0;
    localparam logic [5:0] NORM_LAST_C = 6'(NORMAL_LAST);
    localparam logic [5:0] DBG_BASE_C  = 6'(DEBUG_BASE);
    localparam logic [5:0] DBG_LAST_C  = 6'(DEBUG_LAST);

    localparam logic [1:0] S_MANUAL = 2'd0;
    localparam logic [1:0] S_AUTO   = 2'd1;
    localparam logic [1:0] S_RFVIEW = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [5:0]         index;
    logic [5:0]         index_next;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_next;
    logic               debug_prev;

    logic step_sync1, step_sync2, step_hist;
    logic back_sync1, back_sync2, back_hist;
    logic [1:0] settle_cnt;
    logic step_pulse, back_pulse;

    logic [5:0] range_base, range_last;
    logic [5:0] index_inc, index_dec, load_value;
    logic       step_only, back_only;

    // Button synchronizers and falling-edge history. After reset the flops
    // read "released"; a button already held low would otherwise look like a
    // fresh press once the real pin level reaches the history flop, so edge
    // detection stays disarmed until the pipeline holds genuine samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_sync1 <= 1'b1;
            step_sync2 <= 1'b1;
            step_hist  <= 1'b1;
            back_sync1 <= 1'b1;
            back_sync2 <= 1'b1;
            back_hist  <= 1'b1;
            settle_cnt <= 2'd0;
        end else begin
            step_sync1 <= step_button;
            step_sync2 <= step_sync1;
            step_hist  <= step_sync2;
            back_sync1 <= back_button;
            back_sync2 <= back_sync1;
            back_hist  <= back_sync2;
            if (settle_cnt != 2'd3) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
        end
    end

    assign step_pulse = step_hist & ~step_sync2 & (settle_cnt == 2'd3);
    assign back_pulse = back_hist & ~back_sync2 & (settle_cnt == 2'd3);

    // Simultaneous step and back cancel each other.
    assign step_only = step_pulse & ~back_pulse;
    assign back_only = back_pulse & ~step_pulse;

    assign range_base = debug_mode ? DBG_BASE_C : NORM_BASE_C;
    assign range_last = debug_mode ? DBG_LAST_C : NORM_LAST_C;

    assign index_inc  = (index == range_last) ? range_base : index + 6'd1;
    assign index_dec  = (index == range_base) ? range_last : index - 6'd1;
    assign load_value = ((manual_select >= range_base) && (manual_select <= range_last))
                        ? manual_select : range_base;

    // State transitions; a register-file request wins from any state.
    always_comb begin
        state_next = state;
        if (rf_view_request) begin
            state_next = S_RFVIEW;
        end else begin
            case (state)
                S_MANUAL: if (mode_auto)  state_next = S_AUTO;
                S_AUTO:   if (!mode_auto) state_next = S_MANUAL;
                S_RFVIEW: state_next = mode_auto ? S_AUTO : S_MANUAL;
                default:  state_next = S_MANUAL;
            endcase
        end
    end

    // View index and dwell counter. The rules of the current state apply
    // first, then entry into auto clears the dwell, and a debug-range change
    // finally overrides everything by jumping to the new range base.
    always_comb begin
        index_next = index;
        dwell_next = dwell;
        case (state)
            S_MANUAL: begin
                dwell_next = '0;
                if (manual_load)    index_next = load_value;
                else if (step_only) index_next = index_inc;
                else if (back_only) index_next = index_dec;
            end
            S_AUTO: begin
                if (step_only) begin
                    index_next = index_inc;
                    dwell_next = '0;
                end else if (back_only) begin
                    index_next = index_dec;
                    dwell_next = '0;
                end else if (dwell == DWELL_LAST) begin
                    index_next = index_inc;
                    dwell_next = '0;
                end else begin
                    dwell_next = dwell + DWELL_W'(1);
                end
            end
            default: begin
                index_next = index;
                dwell_next = dwell;
            end
        endcase
        if ((state_next == S_AUTO) && (state != S_AUTO)) begin
            dwell_next = '0;
        end
        if (debug_mode != debug_prev) begin
            index_next = range_base;
            dwell_next = '0;
        end
    end

    // State and output registers; the status flags are registered from the
    // next state so they line up exactly with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_MANUAL;
            index          <= 6'd0;
            dwell          <= '0;
            debug_prev     <= 1'b0;
            display_enable <= 1'b0;
            auto_active    <= 1'b0;
        end else begin
            state          <= state_next;
            index          <= index_next;
            dwell          <= dwell_next;
            debug_prev     <= debug_mode;
            display_enable <= (state_next == S_RFVIEW);
            auto_active    <= (state_next == S_AUTO);
        end
    end

    assign display_select = index;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//
// Self-checking bench for display_scan_controller with a short dwell of four
// clocks. Expected output triples {auto_active, display_enable,
// display_select} are pushed to a scoreboard when stimulus is driven and
// popped and compared once the DUT has had the stated number of clocks.

module tb_display_scan_controller;

    logic       clk;
    logic       reset;
    logic       mode_auto;
    logic       debug_mode;
    logic       step_button;
    logic       back_button;
    logic       manual_load;
    logic [5:0] manual_select;
    logic       rf_view_request;
    logic [5:0] display_select;
    logic       display_enable;
    logic       auto_active;

    int total_count = 0;
    int bad_count   = 0;

    typedef struct {
        string      tag;
        logic [5:0] sel;
        logic       en;
        logic       au;
    } exp_t;

    exp_t scoreboard[$];

    display_scan_controller #(
        .DWELL_CYCLES(4),
        .NORMAL_LAST (26),
        .DEBUG_BASE  (32),
        .DEBUG_LAST  (38)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_auto      (mode_auto),
        .debug_mode     (debug_mode),
        .step_button    (step_button),
        .back_button    (back_button),
        .manual_load    (manual_load),
        .manual_select  (manual_select),
        .rf_view_request(rf_view_request),
        .display_select (display_select),
        .display_enable (display_enable),
        .auto_active    (auto_active)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got au/en/sel=%b/%b/%0d want %b/%b/%0d",
                     tag, observed[7], observed[6], observed[5:0],
                     expected[7], expected[6], expected[5:0]);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [5:0] sel,
                            input logic en, input logic au);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.en  = en;
        e.au  = au;
        scoreboard.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = scoreboard.pop_front();
        check_output(e.tag, {auto_active, display_enable, display_select},
                     {e.au, e.en, e.sel});
    endtask

    task automatic expect_after(input string tag, input int n, input logic [5:0] sel,
                                input logic en, input logic au);
        push_exp(tag, sel, en, au);
        tick(n);
        pop_check();
    endtask

    task automatic load_view(input string tag, input logic [5:0] value,
                             input logic [5:0] sel, input logic au);
        manual_select = value;
        manual_load   = 1'b1;
        expect_after(tag, 1, sel, 1'b0, au);
        manual_load   = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        mode_auto       = 1'b0;
        debug_mode      = 1'b0;
        step_button     = 1'b1;
        back_button     = 1'b1;
        manual_load     = 1'b0;
        manual_select   = 6'd0;
        rf_view_request = 1'b0;

        expect_after("reset", 2, 6'd0, 1'b0, 1'b0);
        reset = 1'b0;
        expect_after("idle", 4, 6'd0, 1'b0, 1'b0);

        // Manual stepping: index changes exactly three clocks after the pin
        // falls, holding the button adds nothing.
        for (int k = 1; k <= 3; k++) begin
            step_button = 1'b0;
            expect_after($sformatf("step%0d_early", k), 2, 6'(k - 1), 1'b0, 1'b0);
            expect_after($sformatf("step%0d", k), 1, 6'(k), 1'b0, 1'b0);
            if (k == 3) expect_after("step_hold", 20, 6'd3, 1'b0, 1'b0);
            step_button = 1'b1;
            expect_after($sformatf("step%0d_rel", k), 3, 6'(k), 1'b0, 1'b0);
        end

        // Wrap at the top of the normal range, back-wrap, and cancellation.
        load_view("load26", 6'd26, 6'd26, 1'b0);
        step_button = 1'b0;
        expect_after("wrap_step", 3, 6'd0, 1'b0, 1'b0);
        step_button = 1'b1;
        expect_after("wrap_step_rel", 3, 6'd0, 1'b0, 1'b0);
        back_button = 1'b0;
        expect_after("wrap_back", 3, 6'd26, 1'b0, 1'b0);
        back_button = 1'b1;
        expect_after("wrap_back_rel", 3, 6'd26, 1'b0, 1'b0);
        step_button = 1'b0;
        back_button = 1'b0;
        expect_after("cancel", 3, 6'd26, 1'b0, 1'b0);
        expect_after("cancel_hold", 2, 6'd26, 1'b0, 1'b0);
        step_button = 1'b1;
        back_button = 1'b1;
        expect_after("cancel_rel", 3, 6'd26, 1'b0, 1'b0);

        // Manual load clamps out-of-range codes to the range base.
        load_view("load5", 6'd5, 6'd5, 1'b0);
        load_view("load30_oor", 6'd30, 6'd0, 1'b0);

        // Auto scan from index 0 with a four-clock dwell.
        mode_auto = 1'b1;
        expect_after("auto_enter", 1, 6'd0, 1'b0, 1'b1);
        expect_after("auto_dwell", 3, 6'd0, 1'b0, 1'b1);
        expect_after("auto_adv1", 1, 6'd1, 1'b0, 1'b1);
        expect_after("auto_adv2", 4, 6'd2, 1'b0, 1'b1);
        expect_after("auto_adv3", 4, 6'd3, 1'b0, 1'b1);

        // Step pulse lands on the dwell terminal cycle: one advance only.
        tick(1);
        step_button = 1'b0;
        expect_after("step_on_tc", 3, 6'd4, 1'b0, 1'b1);
        expect_after("tc_restart_hold", 3, 6'd4, 1'b0, 1'b1);
        step_button = 1'b1;
        expect_after("tc_restart_adv", 1, 6'd5, 1'b0, 1'b1);

        // Register-file view holds index 5; a press during it is discarded.
        rf_view_request = 1'b1;
        expect_after("rf_enter", 1, 6'd5, 1'b1, 1'b0);
        step_button = 1'b0;
        expect_after("rf_btn_discard", 4, 6'd5, 1'b1, 1'b0);
        step_button = 1'b1;
        expect_after("rf_hold", 5, 6'd5, 1'b1, 1'b0);
        rf_view_request = 1'b0;
        expect_after("rf_exit", 1, 6'd5, 1'b0, 1'b1);
        expect_after("resume_hold", 3, 6'd5, 1'b0, 1'b1);
        expect_after("resume_adv", 1, 6'd6, 1'b0, 1'b1);

        // Debug range: change jumps to base, auto wraps 38 -> 32, loads clamp.
        mode_auto = 1'b0;
        expect_after("to_manual", 1, 6'd6, 1'b0, 1'b0);
        load_view("load12", 6'd12, 6'd12, 1'b0);
        debug_mode = 1'b1;
        expect_after("dbg_enter", 1, 6'd32, 1'b0, 1'b0);
        load_view("dbg_load38", 6'd38, 6'd38, 1'b0);
        mode_auto = 1'b1;
        expect_after("dbg_auto_enter", 1, 6'd38, 1'b0, 1'b1);
        expect_after("dbg_auto_hold", 3, 6'd38, 1'b0, 1'b1);
        expect_after("dbg_wrap", 1, 6'd32, 1'b0, 1'b1);
        mode_auto = 1'b0;
        expect_after("dbg_manual", 1, 6'd32, 1'b0, 1'b0);
        load_view("dbg_load5", 6'd5, 6'd32, 1'b0);
        load_view("dbg_load35", 6'd35, 6'd35, 1'b0);
        back_button = 1'b0;
        expect_after("dbg_back", 3, 6'd34, 1'b0, 1'b0);
        back_button = 1'b1;
        expect_after("dbg_back_rel", 3, 6'd34, 1'b0, 1'b0);
        debug_mode = 1'b0;
        expect_after("dbg_exit", 1, 6'd0, 1'b0, 1'b0);

        // Reset mid-scan with the step pin held low.
        load_view("load20", 6'd20, 6'd20, 1'b0);
        mode_auto = 1'b1;
        expect_after("pre_reset_auto", 1, 6'd20, 1'b0, 1'b1);
        tick(1);
        step_button = 1'b0;
        tick(1);
        reset     = 1'b1;
        mode_auto = 1'b0;
        expect_after("mid_reset", 1, 6'd0, 1'b0, 1'b0);
        reset = 1'b0;
        expect_after("held_no_adv", 10, 6'd0, 1'b0, 1'b0);
        step_button = 1'b1;
        expect_after("held_rel", 3, 6'd0, 1'b0, 1'b0);
        step_button = 1'b0;
        expect_after("new_press", 3, 6'd1, 1'b0, 1'b0);
        step_button = 1'b1;
        tick(3);

        check_output("sb_empty", 8'(scoreboard.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter: DWELL_CYCLES, default 50000000, auto-scan dwell per view in clocks (1 s at 50 MHz).
REQ-002 Parameter: NORMAL_LAST, default 26, last select code of the normal view range (range 0..NORMAL_LAST).
REQ-003 Parameter: DEBUG_BASE, default 32, first select code of the debug view range.
REQ-004 Parameter: DEBUG_LAST, default 38, last select code of the debug view range.
REQ-005 Clock  input  1  single clock, all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Mode_Auto  input  1  1 = auto-scan views, 0 = manual stepping.
REQ-008 Debug_Mode  input  1  0 = normal range, 1 = debug range.
REQ-009 Step_Button  input  1  active-low pushbutton, asynchronous to Clock; press = advance one view.
REQ-010 Back_Button  input  1  active-low pushbutton, asynchronous to Clock; press = go back one view.
REQ-011 Manual_Load  input  1  synchronous load strobe for Manual_Select.
REQ-012 Manual_Select  input  6  view code loaded on Manual_Load.
REQ-013 RF_View_Request  input  1  level request to show the register-file view.
REQ-014 Display_Select  output  6  registered view code driven to the display mux.
REQ-015 Display_Enable  output  1  registered; 1 = display mux shows the register-file view.
REQ-016 Auto_Active  output  1  registered; 1 while in S_AUTO.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer; a 1->0 transition of the synchronized level SHALL produce exactly one 1-cycle pulse, visible in the index 3 clocks after the pin falls; holding the button low SHALL produce no further pulses.
REQ-018 States: S_MANUAL, S_AUTO, S_RFVIEW.
REQ-019 Transitions: any state with RF_View_Request=1 -> S_RFVIEW; S_RFVIEW with RF_View_Request=0 -> S_AUTO if Mode_Auto=1 else S_MANUAL; S_MANUAL with Mode_Auto=1 -> S_AUTO; S_AUTO with Mode_Auto=0 -> S_MANUAL.
REQ-020 Display_Enable SHALL be 1 exactly in cycles where state is S_RFVIEW (registered with state); Auto_Active likewise for S_AUTO.
REQ-021 Active range: base=0,last=NORMAL_LAST when Debug_Mode=0; base=DEBUG_BASE,last=DEBUG_LAST when Debug_Mode=1.
REQ-022 A change of Debug_Mode (registered-edge compare) SHALL load index=new base and clear dwell counter next cycle, overriding all other index updates.
REQ-023 Step pulse: index = (index==last) ? base : index+1. Back pulse: index = (index==base) ? last : index-1.
REQ-024 Step and Back pulses in the same cycle SHALL cancel: index unchanged.
REQ-025 S_MANUAL: Manual_Load=1 SHALL load Manual_Select if base<=Manual_Select<=last, else base; Manual_Load has priority over step/back pulses; Manual_Load ignored in other states.
REQ-026 S_AUTO: dwell counter counts 0..DWELL_CYCLES-1; at DWELL_CYCLES-1 index advances as in REQ-023 and counter clears.
REQ-027 S_AUTO: step/back pulse SHALL apply immediately and clear the dwell counter; it has priority over dwell terminal count in the same cycle.
REQ-028 Entering S_AUTO from any state SHALL clear the dwell counter; S_MANUAL holds counter at 0.
REQ-029 S_RFVIEW: index and dwell counter SHALL hold; button pulses discarded (not queued).
REQ-030 Display_Select SHALL equal the index register; it SHALL never hold a value outside the active range except for one cycle after a Debug_Mode change.
REQ-031 Dwell counter width SHALL be clog2(DWELL_CYCLES), minimum 1 bit; DWELL_CYCLES=1 advances every clock.

Reset
REQ-032 Reset=1 at a rising edge SHALL set state=S_MANUAL, index=0 (Display_Select=0), Display_Enable=0, Auto_Active=0, dwell counter=0, synchronizer flops=1 (released), Debug_Mode history=0.
REQ-033 Reset mid-scan SHALL abandon any in-flight button pulse; first state evaluation follows on the clock after Reset deasserts.

Verification (DWELL_CYCLES=4)
REQ-034 Reset, Mode_Auto=0, press Step 3 times -> Display_Select 1,2,3, each 3 clocks after the press; holding the button low 20 clocks adds nothing.
REQ-035 Manual, index=26, Step -> 0; Back -> 26; Step and Back pressed same synchronized cycle -> unchanged.
REQ-036 Mode_Auto=1 from index 0 -> Auto_Active=1, Display_Select advances to 1,2,3 every 4 clocks; Step on dwell terminal cycle -> single advance, counter restarts.
REQ-037 Auto at index 5, RF_View_Request=1 for 10 clocks -> Display_Enable=1, Display_Select holds 5; drop request -> Display_Enable=0, auto resumes, next advance 4 clocks later.
REQ-038 Debug_Mode 0->1 at index 12 -> Display_Select=32; auto wraps 38->32; Manual_Load 5 in debug range -> 32; Manual_Load 35 -> 35.
REQ-039 Reset asserted during auto at index 20 with Step pin low -> outputs 0/0/0 next clock, no advance after release until a new press.
